// File: rtl/mips_cpu_mem_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto a single Avalon-MM
// master; one transaction at a time through IDLE -> ACCESS -> DONE.
module mips_cpu_mem_arbiter #(
    parameter bit RR = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        ls_req,
    input  logic        ls_write,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_byteenable,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        grant_ls;
    logic        last_ls;
    logic        any_req;
    logic        pick_ls;
    logic        pick_store;
    logic        zero_store;
    logic [31:0] cmd_addr;

    // A tie goes to load/store unless round-robin says fetch is owed a turn.
    always_comb begin
        any_req    = if_req | ls_req;
        pick_ls    = ls_req & (~if_req | ~RR | ~last_ls);
        pick_store = pick_ls & ls_write;
        zero_store = pick_store & (ls_byteenable == 4'b0000);
        cmd_addr   = (pick_ls ? ls_addr : if_addr) & 32'hFFFF_FFFC;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = zero_store ? DONE : ACCESS;
            ACCESS:  if (!avm_waitrequest) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        if_done   = (state == DONE) & ~grant_ls;
        ls_done   = (state == DONE) & grant_ls;
        state_dbg = state;
    end

    // Bus command is latched once in IDLE so requester changes during ACCESS cannot leak onto the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_ls       <= 1'b0;
            last_ls        <= 1'b0;
            avm_address    <= 32'h0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= 32'h0;
            avm_byteenable <= 4'h0;
            if_rdata       <= 32'h0;
            ls_rdata       <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_ls <= pick_ls;
                        last_ls  <= pick_ls;
                        if (!zero_store) begin
                            avm_address    <= cmd_addr;
                            avm_read       <= ~pick_store;
                            avm_write      <= pick_store;
                            avm_byteenable <= pick_store ? ls_byteenable : 4'hF;
                            if (pick_store) avm_writedata <= ls_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        if (avm_read) begin
                            if (grant_ls) ls_rdata <= avm_readdata;
                            else          if_rdata <= avm_readdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Bench for mips_cpu_mem_arbiter: table of transactions, rdata scoreboard,
// hand-written tie, zero-enable and reset-mid-access sequences.
module tb_mips_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, ls_req, ls_write, avm_waitrequest;
    logic [31:0] if_addr, ls_addr, ls_wdata, avm_readdata;
    logic [3:0]  ls_byteenable;

    logic [31:0] if_rdata, ls_rdata, avm_address, avm_writedata;
    logic        if_done, ls_done, avm_read, avm_write, busy;
    logic [3:0]  avm_byteenable;
    logic [1:0]  state_dbg;

    logic [31:0] if_rdata_1, ls_rdata_1, avm_address_1, avm_writedata_1;
    logic        if_done_1, ls_done_1, avm_read_1, avm_write_1, busy_1;
    logic [3:0]  avm_byteenable_1;
    logic [1:0]  state_dbg_1;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_ls;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
    } vec_t;

    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic [31:0] ls_model, if_model;

    always #5 clk = ~clk;

    mips_cpu_mem_arbiter #(.RR(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .ls_req(ls_req), .ls_write(ls_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_byteenable(ls_byteenable), .ls_rdata(ls_rdata), .ls_done(ls_done),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .busy(busy), .state_dbg(state_dbg)
    );

    mips_cpu_mem_arbiter #(.RR(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_1), .if_done(if_done_1),
        .ls_req(ls_req), .ls_write(ls_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_byteenable(ls_byteenable), .ls_rdata(ls_rdata_1), .ls_done(ls_done_1),
        .avm_address(avm_address_1), .avm_read(avm_read_1), .avm_write(avm_write_1),
        .avm_writedata(avm_writedata_1), .avm_byteenable(avm_byteenable_1),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .busy(busy_1), .state_dbg(state_dbg_1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse pops one expected {port, rdata} entry.
    always @(negedge clk) begin
        if (reset_n && (if_done || ls_done)) begin
            if (exp_q.size() == 0) begin
                check_bit("unexpected_done", 1'b1, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check_bit("done_port", ls_done, mon_e[32]);
                check("rdata", mon_e[32] ? ls_rdata : if_rdata, mon_e[31:0]);
            end
        end
    end

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (if_done || ls_done) seen = 1'b1;
        end
        if (!seen) check_bit("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_txn(input vec_t v);
        bit st, zero;
        st   = v.is_ls && v.write;
        zero = st && (v.be == 4'b0000);
        @(posedge clk); #1;
        if (v.is_ls) begin
            ls_req = 1'b1; ls_write = v.write; ls_addr = v.addr;
            ls_wdata = v.wdata; ls_byteenable = v.be;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        avm_readdata    = v.rdata;
        avm_waitrequest = (v.waits > 0);
        if (!st) begin
            exp_q.push_back({v.is_ls, v.rdata});
            if (v.is_ls) ls_model = v.rdata; else if_model = v.rdata;
        end else begin
            exp_q.push_back({1'b1, ls_model});
        end
        @(posedge clk);
        if (!zero) begin
            for (int w = 0; w <= v.waits; w++) begin
                @(negedge clk);
                check_bit("avm_read", avm_read, !st);
                check_bit("avm_write", avm_write, st);
                check("avm_address", avm_address, v.exp_addr);
                check("avm_byteenable", {28'h0, avm_byteenable}, {28'h0, v.exp_be});
                if (st) check("avm_writedata", avm_writedata, v.wdata);
                check_bit("early_done", if_done | ls_done, 1'b0);
                ls_addr = $urandom; if_addr = $urandom; ls_wdata = $urandom;
                ls_byteenable = 4'($urandom_range(0, 15));
                avm_waitrequest = (w < v.waits);
                @(posedge clk);
            end
        end
        @(negedge clk);
        check_bit("done_pulse", v.is_ls ? ls_done : if_done, 1'b1);
        check_bit("other_done", v.is_ls ? if_done : ls_done, 1'b0);
        check_bit("strobes_off", avm_read | avm_write, 1'b0);
        check_bit("busy_done", busy, 1'b1);
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0; avm_waitrequest = 1'b0;
        @(negedge clk);
        check_bit("done_one_cycle", if_done | ls_done, 1'b0);
        check_bit("busy_idle", busy, 1'b0);
        check_bit("no_write_after", avm_write, 1'b0);
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; if_req = 0; ls_req = 0; ls_write = 0; avm_waitrequest = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_byteenable = 0; avm_readdata = 0;
        ls_model = 32'h0; if_model = 32'h0;

        vecs[0] = '{0, 0, 32'hBFC00002, 32'h0, 4'h0, 0, 32'h24020005, 32'hBFC00000, 4'hF};
        vecs[1] = '{1, 0, 32'h00001004, 32'h0, 4'h0, 3, 32'hDEADBEEF, 32'h00001004, 4'hF};
        vecs[2] = '{1, 1, 32'h00002003, 32'hAB000000, 4'b1000, 0, 32'h55555555, 32'h00002000, 4'b1000};
        vecs[3] = '{1, 1, 32'h00003000, 32'h12345678, 4'b0000, 0, 32'h66666666, 32'h00003000, 4'b0000};
        vecs[4] = '{0, 0, 32'h00400007, 32'h0, 4'h0, 2, 32'h12345678, 32'h00400004, 4'hF};
        vecs[5] = '{1, 0, 32'h7FFFFFFF, 32'h0, 4'h0, 1, 32'hCAFEF00D, 32'h7FFFFFFC, 4'hF};
        vecs[6] = '{1, 1, 32'h00000010, 32'h0000BEEF, 4'b0011, 2, 32'h77777777, 32'h00000010, 4'b0011};
        vecs[7] = '{1, 1, 32'hFFFFFFFE, 32'hFFFFFFFF, 4'b0000, 0, 32'h0, 32'hFFFFFFFC, 4'b0000};

        #1;
        check_bit("rst_avm_read", avm_read, 1'b0);
        check_bit("rst_avm_write", avm_write, 1'b0);
        check_bit("rst_if_done", if_done, 1'b0);
        check_bit("rst_ls_done", ls_done, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check("rst_avm_address", avm_address, 32'h0);
        check("rst_avm_writedata", avm_writedata, 32'h0);
        check("rst_avm_byteenable", {28'h0, avm_byteenable}, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_ls_rdata", ls_rdata, 32'h0);
        check("rst_state", {30'h0, state_dbg}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            rv.is_ls = 1'($urandom_range(0, 1));
            rv.write = rv.is_ls && ($urandom_range(0, 1) == 1);
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.be    = 4'($urandom_range(0, 15));
            rv.waits = $urandom_range(0, 3);
            rv.rdata = $urandom;
            rv.exp_addr = {rv.addr[31:2], 2'b00};
            rv.exp_be   = rv.write ? rv.be : 4'hF;
            run_txn(rv);
        end

        // Tie with both requests held: load/store first, then fetch.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100; ls_req = 1'b1; ls_write = 1'b0; ls_addr = 32'h200;
        avm_waitrequest = 1'b0; avm_readdata = 32'h11111111;
        exp_q.push_back({1'b1, 32'h11111111});
        exp_q.push_back({1'b0, 32'h22222222});
        ls_model = 32'h11111111; if_model = 32'h22222222;
        wait_done();
        check_bit("tie_ls_first", ls_done, 1'b1);
        @(posedge clk); #1;
        ls_req = 1'b0; avm_readdata = 32'h22222222;
        wait_done();
        check_bit("tie_fetch_second", if_done, 1'b1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);

        // Reset in the middle of a stalled load.
        @(posedge clk); #1;
        ls_req = 1'b1; ls_write = 1'b0; ls_addr = 32'h4000; avm_waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_bit("pre_reset_read", avm_read, 1'b1);
        #2;
        reset_n = 1'b0; ls_req = 1'b0;
        #1;
        check_bit("mid_reset_read", avm_read, 1'b0);
        check_bit("mid_reset_write", avm_write, 1'b0);
        check_bit("mid_reset_busy", busy, 1'b0);
        check("mid_reset_ls_rdata", ls_rdata, 32'h0);
        ls_model = 32'h0; if_model = 32'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1; avm_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_bit("post_reset_quiet", if_done | ls_done | busy, 1'b0);
        end
        run_txn(vecs[0]);

        // Three separate ties: RR=0 always grants load/store, RR=1 alternates.
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            if_req = 1'b1; if_addr = 32'h500; ls_req = 1'b1; ls_write = 1'b0; ls_addr = 32'h600;
            avm_readdata = 32'h33333333;
            exp_q.push_back({1'b1, 32'h33333333});
            ls_model = 32'h33333333;
            wait_done();
            check_bit("rr0_tie_ls", ls_done, 1'b1);
            check_bit("rr1_tie_ls", ls_done_1, t != 1);
            check_bit("rr1_tie_if", if_done_1, t == 1);
            @(posedge clk); #1;
            if_req = 1'b0; ls_req = 1'b0;
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_mem_arbiter.md
MIPS_CPU_MEM_ARBITER -- requirements
Module: mips_cpu_mem_arbiter

Interface
REQ-001 Parameter: RR, 0, tie-break policy (0 = load/store always wins; 1 = round-robin between fetch and load/store).
REQ-002 The block SHALL use one clock and one reset; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 if_req  in  1  instruction-fetch request, held until if_done.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_rdata  out  32  registered fetch read data.
REQ-008 if_done  out  1  one-cycle fetch completion pulse.
REQ-009 ls_req  in  1  load/store request, held until ls_done.
REQ-010 ls_write  in  1  1 = store, 0 = load.
REQ-011 ls_addr  in  32  load/store byte address.
REQ-012 ls_wdata  in  32  store data, already lane-shifted.
REQ-013 ls_byteenable  in  4  store lane enables.
REQ-014 ls_rdata  out  32  registered load read data (full word).
REQ-015 ls_done  out  1  one-cycle load/store completion pulse.
REQ-016 avm_address  out  32  word-aligned bus address.
REQ-017 avm_read / avm_write  out  1 each  bus strobes.
REQ-018 avm_writedata  out  32  bus write data.
REQ-019 avm_byteenable  out  4  bus lane enables.
REQ-020 avm_waitrequest  in  1  slave stall.
REQ-021 avm_readdata  in  32  bus read data.
REQ-022 busy  out  1  high in any state other than IDLE.

Function
REQ-023 The FSM SHALL have exactly three states (IDLE, ACCESS, DONE); all outputs SHALL be registered or decoded from registered state only.
REQ-024 In IDLE, at a clock edge with a request present, the block SHALL latch the winner's command into bus registers, record the grant, and go to ACCESS.
REQ-025 Arbitration: when only one request is present, it wins; when both are present, ls wins if RR=0; if RR=1, the port not granted last wins, and last_grant resets to fetch, so the first tie goes to ls.
REQ-026 avm_address SHALL be {addr[31:2],2'b00}; a fetch SHALL drive avm_read=1 and avm_byteenable=4'b1111; a load SHALL drive avm_read=1 and 4'b1111; a store SHALL drive avm_write=1, ls_wdata and ls_byteenable.
REQ-027 In ACCESS, address, data, byteenable and strobe SHALL remain stable while avm_waitrequest=1.
REQ-028 At the first edge in ACCESS with avm_waitrequest=0, the block SHALL capture avm_readdata into if_rdata or ls_rdata (reads only), drop strobes, and go to DONE.
REQ-029 In DONE, the granted port's done SHALL be 1 for exactly one cycle; the block SHALL ignore requests; next state SHALL be IDLE.
REQ-030 Latency: a request sampled at edge N with zero wait SHALL give a strobe in cycle N+1 and done in cycle N+2; each waitrequest cycle adds one.
REQ-031 A requester SHALL drop req at the edge where it samples done=1; a req still high in IDLE SHALL be treated as a new request.
REQ-032 A store with ls_byteenable=4'b0000 SHALL issue no bus cycle: IDLE to DONE directly, with ls_done pulsing in cycle N+1.
REQ-033 Write-only transactions SHALL leave ls_rdata and if_rdata unchanged; rdata registers SHALL hold until the next read completion for that port.
REQ-034 Changes to request inputs during ACCESS SHALL NOT affect the bus command in flight.

Reset
REQ-035 Asynchronously on reset_n=0: state=IDLE; avm_read=avm_write=0; if_done=ls_done=busy=0; avm_address, avm_writedata, avm_byteenable, if_rdata, ls_rdata=0; last_grant=fetch.
REQ-036 Reset asserted during ACCESS SHALL drop strobes immediately, abandon the transaction, and generate no done pulse after release.

Verification
REQ-037 Fetch only: if_req=1, if_addr=0xBFC00002, waitrequest=0, readdata=0x24020005 -> avm_address=0xBFC00000, avm_read for 1 cycle, if_done at N+2, if_rdata=0x24020005.
REQ-038 Stall: ls load from 0x1004 with waitrequest=1 for 3 cycles -> strobe and address stable for 4 cycles, ls_done at N+5, ls_rdata=readdata.
REQ-039 Tie: both requests at the same edge; RR=0 -> ls then fetch on every tie; RR=1 -> ls, fetch, ls alternating across three back-to-back ties.
REQ-040 Store: ls_write=1, addr=0x2003, be=4'b1000, wdata=0xAB000000 -> avm_write=1, byteenable=4'b1000, address=0x2000, ls_rdata unchanged.
REQ-041 Zero-byteenable store -> no avm_write ever asserted, ls_done at N+1.
REQ-042 reset_n low mid-ACCESS with waitrequest=1 -> strobes 0 the same cycle, no done after release, next request is served normally.
